// File: rtl/cordicatan_pkg.sv
// Shared fixed-point constants for the CORDIC blocks: angle scale, atan table, gain shifts.
package cordicatan_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned XY_W   = 19;
  localparam int unsigned Z_W    = 18;
  localparam int unsigned IDX_W  = 4;

  localparam int unsigned FIX_SHIFT = 12;
  localparam int unsigned PI2       = 6434;
  localparam int unsigned PI2_X2    = 2 * PI2;
  localparam int unsigned PI2_X4    = 4 * PI2;

  // Gain compensation K ~ 0.6074 as (x>>1) + (x>>3) - (x>>6) - (x>>9)
  localparam int unsigned K_SH_A = 1;
  localparam int unsigned K_SH_B = 3;
  localparam int unsigned K_SH_C = 6;
  localparam int unsigned K_SH_D = 9;

  // round(atan(2^-i) * 2^12), i = 0..15
  localparam logic [DATA_W-1:0] ATAN_TAB [16] = '{
    16'd3217, 16'd1899, 16'd1003, 16'd509,
    16'd256,  16'd128,  16'd64,   16'd32,
    16'd16,   16'd8,    16'd4,    16'd2,
    16'd1,    16'd0,    16'd0,    16'd0
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_COMPUTE,
    S_SCALE,
    S_DONE
  } state_t;

endpackage

// File: rtl/cordicatan_if.sv
// update/ready handshake plus vector inputs and polar outputs.
interface cordicatan_if;
  import cordicatan_pkg::*;

  logic              update;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic              ready;
  logic [DATA_W-1:0] out_angle;
  logic [DATA_W-1:0] out_mag;

  modport master (
    output update, in_x, in_y,
    input  ready, out_angle, out_mag
  );

  modport slave (
    input  update, in_x, in_y,
    output ready, out_angle, out_mag
  );
endinterface

// File: rtl/cordicatantab.sv
// Combinational micro-rotation angle lookup, index -> atan(2^-i) in Q4.12.
module cordicatantab
  import cordicatan_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] atan_c
);

  assign atan_c = ATAN_TAB[idx];

endmodule

// File: rtl/cordicatan.sv
// Iterative vectoring-mode CORDIC: (x, y) -> unsigned angle word and compensated magnitude.
module cordicatan
  import cordicatan_pkg::*;
#(
  parameter int unsigned ITER = 16
) (
  input  logic clk,
  input  logic reset,
  cordicatan_if.slave bus
);

  localparam logic signed [Z_W-1:0] BASE_NEG = Z_W'(PI2_X2);
  localparam logic signed [Z_W-1:0] WRAP     = Z_W'(PI2_X4);
  localparam logic [IDX_W-1:0]      LAST     = IDX_W'(ITER - 1);

  state_t state_q, state_d;

  logic signed [XY_W-1:0] x_q, y_q;
  logic signed [Z_W-1:0]  z_q, base_q;
  logic                   zero_q;
  logic [IDX_W-1:0]       cnt_q;
  logic                   ready_q;
  logic [DATA_W-1:0]      angle_q, mag_q;

  logic [DATA_W-1:0]      atan_c;
  logic signed [Z_W-1:0]  atan_ext;
  logic signed [XY_W-1:0] xs, ys;
  logic signed [Z_W-1:0]  angle_sum;

  cordicatantab u_tab (
    .idx    (cnt_q),
    .atan_c (atan_c)
  );

  assign atan_ext  = $signed({2'b00, atan_c});
  assign xs        = x_q >>> cnt_q;
  assign ys        = y_q >>> cnt_q;
  assign angle_sum = base_q + z_q;

  assign bus.ready     = ready_q;
  assign bus.out_angle = angle_q;
  assign bus.out_mag   = mag_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; update is only honoured while idle or done
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.update) state_d = S_INIT;
      S_INIT:         state_d = S_COMPUTE;
      S_COMPUTE:      if (cnt_q == LAST) state_d = S_SCALE;
      S_SCALE:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath: latch, fold into right half-plane, rotate, then scale outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      base_q  <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      ready_q <= (state_d == S_IDLE) || (state_d == S_DONE);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.update) begin
            x_q   <= XY_W'($signed(bus.in_x));
            y_q   <= XY_W'($signed(bus.in_y));
            cnt_q <= '0;
          end
        end
        S_INIT: begin
          if (x_q < 0) begin
            x_q    <= -x_q;
            y_q    <= -y_q;
            base_q <= BASE_NEG;
          end else begin
            base_q <= '0;
          end
          z_q    <= '0;
          zero_q <= (x_q == 0) && (y_q == 0);
          cnt_q  <= '0;
        end
        S_COMPUTE: begin
          if (!y_q[XY_W-1]) begin
            x_q <= x_q + ys;
            y_q <= y_q - xs;
            z_q <= z_q + atan_ext;
          end else begin
            x_q <= x_q - ys;
            y_q <= y_q + xs;
            z_q <= z_q - atan_ext;
          end
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + IDX_W'(1);
        end
        S_SCALE: begin
          if (zero_q) begin
            angle_q <= '0;
            mag_q   <= '0;
          end else begin
            angle_q <= DATA_W'((angle_sum < 0) ? angle_sum + WRAP : angle_sum);
            mag_q   <= DATA_W'((x_q >>> K_SH_A) + (x_q >>> K_SH_B)
                               - (x_q >>> K_SH_C) - (x_q >>> K_SH_D));
          end
        end
        default: ;
      endcase
    end
  end

endmodule
